// File: rtl/mem_req_pkg.sv
// Shared types and widths for the memory requester: command payload and FSM state encoding.
package mem_req_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw;
    } mem_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// Command queue for mem_requester: DEPTH entries of mem_cmd_t, wrapping pointers, full/empty flags.
module mem_req_fifo
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  mem_cmd_t din,
    input  logic     pop,
    output mem_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    mem_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_requester.sv
// Queues pipeline memory commands and issues them one at a time to the cache, returning in-order responses.
// Optional MEM_REQ_TIMEOUT_EN aborts a request after TIMEOUT_CYCLES without a cache response.
module mem_requester
    import mem_req_pkg::*;
#(
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_rw,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] cpu_req_addr,
    output logic [DATA_W-1:0] cpu_req_data,
    output logic              cpu_req_rw,
    output logic              cpu_req_valid,
    input  logic [DATA_W-1:0] cpu_res_data,
    input  logic              cpu_res_ready,
    output mem_state_e        state_dbg
);

    // Handshake: a command transfers on the sys_clk edge where cmd_valid && cmd_ready;
    // the cache request is held until the edge where cpu_res_ready is seen in REQ.
    mem_state_e state;
    mem_cmd_t   fifo_din;
    mem_cmd_t   head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    assign cmd_ready = !fifo_full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign fifo_din  = '{addr: cmd_addr, data: cmd_wdata, rw: cmd_rw};
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign state_dbg = state;

    mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (sys_clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)                  tmo_cnt <= '0;
        else if (pop)             tmo_cnt <= '0;
        else if (state == ST_REQ) tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cpu_req_valid <= 1'b0;
            cpu_req_addr  <= '0;
            cpu_req_data  <= '0;
            cpu_req_rw    <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
            rsp_err       <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cpu_req_addr  <= head.addr;
                        cpu_req_data  <= head.rw ? head.data : '0;
                        cpu_req_rw    <= head.rw;
                        cpu_req_valid <= 1'b1;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (cpu_res_ready) begin
                        rsp_rdata     <= cpu_req_rw ? '0 : cpu_res_data;
                        rsp_valid     <= 1'b1;
                        cpu_req_valid <= 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
                        rsp_err       <= 1'b0;
`endif
                        state         <= ST_RESP;
                    end
`ifdef MEM_REQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rsp_rdata     <= '0;
                        rsp_valid     <= 1'b1;
                        rsp_err       <= 1'b1;
                        cpu_req_valid <= 1'b0;
                        state         <= ST_RESP;
                    end
`endif
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Randomized scoreboard bench for mem_requester: memory reference model, cache responder model, response monitor.
`timescale 1ns/1ps
module tb_mem_requester;
    import mem_req_pkg::*;

    localparam int TMO = 16;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [26:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_rw;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [26:0] cpu_req_addr;
    logic [31:0] cpu_req_data;
    logic        cpu_req_rw;
    logic        cpu_req_valid;
    logic [31:0] cpu_res_data = 32'h0;
    logic        cpu_res_ready = 1'b0;
    mem_state_e  state_dbg;

    always #5 sys_clk = ~sys_clk;

    mem_requester #(.DEPTH(2), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_rw        (cmd_rw),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_data  (cpu_req_data),
        .cpu_req_rw    (cpu_req_rw),
        .cpu_req_valid (cpu_req_valid),
        .cpu_res_data  (cpu_res_data),
        .cpu_res_ready (cpu_res_ready),
        .state_dbg     (state_dbg)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference memory (command order) and the cache's own backing store.
    logic [31:0] ref_mem   [logic [26:0]];
    logic [31:0] cache_mem [logic [26:0]];
    logic [32:0] exp_q[$];      // {err, rdata}
    logic [59:0] exp_req_q[$];  // {addr, data, rw}

    function automatic logic [31:0] init_word(input logic [26:0] a);
        return 32'hC0DE_0000 ^ {5'b0, a};
    endfunction

    int fixed_lat   = -1;
    bit cache_stall = 1'b0;
    bit force_ready = 1'b0;
    int rsp_count   = 0;

    task automatic issue_model(input logic [26:0] a, input logic [31:0] d, input logic rw, input bit will_timeout);
        exp_req_q.push_back({a, rw ? d : 32'h0, rw});
        if (will_timeout) begin
            exp_q.push_back({1'b1, 32'h0});
        end else if (rw) begin
            exp_q.push_back({1'b0, 32'h0});
            ref_mem[a] = d;
        end else begin
            exp_q.push_back({1'b0, ref_mem.exists(a) ? ref_mem[a] : init_word(a)});
        end
    endtask

    task automatic send_cmd(input logic [26:0] a, input logic [31:0] d, input logic rw, input bit will_timeout);
        int guard = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_rw    = rw;
        while (!cmd_ready && guard < 3000) begin
            @(negedge sys_clk);
            guard++;
        end
        if (guard >= 3000) begin
            check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
        end else begin
            @(posedge sys_clk);
            issue_model(a, d, rw, will_timeout);
        end
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while ((busy || exp_q.size() != 0) && guard < 5000) begin
            @(negedge sys_clk);
            guard++;
        end
        check({name, "_pending_rsp"}, 64'(exp_q.size()), 64'd0);
        check({name, "_pending_req"}, 64'(exp_req_q.size()), 64'd0);
    endtask

    // Cache responder: checks each request against the issued order, then answers after a latency.
    initial begin : cache_model
        logic [59:0] e;
        logic [59:0] held;
        logic        prev_req_valid;
        logic        fire;
        int          wait_cnt;
        int          cur_lat;
        prev_req_valid = 1'b0;
        held = '0;
        wait_cnt = 0;
        cur_lat = 0;
        forever begin
            @(negedge sys_clk);
            fire = 1'b0;
            if (rst) begin
                prev_req_valid = 1'b0;
                wait_cnt = 0;
            end else begin
                if (cpu_req_valid) begin
                    if (!prev_req_valid) begin
                        if (exp_req_q.size() == 0) begin
                            check("req_unexpected", 64'(cpu_req_valid), 64'd0);
                        end else begin
                            e = exp_req_q.pop_front();
                            check("req_addr", 64'(cpu_req_addr), 64'(e[59:33]));
                            check("req_data", 64'(cpu_req_data), 64'(e[32:1]));
                            check("req_rw", 64'(cpu_req_rw), 64'(e[0]));
                        end
                        held = {cpu_req_addr, cpu_req_data, cpu_req_rw};
                        wait_cnt = 0;
                        cur_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 6));
                    end else begin
                        check("req_hold", 64'({cpu_req_addr, cpu_req_data, cpu_req_rw}), 64'(held));
                    end
                    if (!cache_stall && wait_cnt >= cur_lat) begin
                        fire = 1'b1;
                        if (cpu_req_rw) begin
                            cache_mem[cpu_req_addr] = cpu_req_data;
                            cpu_res_data = $urandom;
                        end else begin
                            cpu_res_data = cache_mem.exists(cpu_req_addr) ? cache_mem[cpu_req_addr]
                                                                          : init_word(cpu_req_addr);
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
                prev_req_valid = cpu_req_valid;
            end
            if (!fire) cpu_res_data = $urandom;
            cpu_res_ready = fire || force_ready;
        end
    end

    initial begin : rsp_monitor
        logic [32:0] e;
        logic        prev_rsp;
        prev_rsp = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!rst && rsp_valid) begin
                rsp_count++;
                if (prev_rsp) check("rsp_pulse_width", 64'(prev_rsp), 64'd0);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", 64'(rsp_err), 64'(e[32]));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
                end
            end
            prev_rsp = rsp_valid && !rst;
        end
    end

    initial begin : main
        int n;
        int cnt;
        int g;
        logic [26:0] a;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        cmd_rw = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_valid", 64'(cpu_req_valid), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
        rst = 1'b0;
        @(negedge sys_clk);
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        // Single read answered 5 cycles after the request
        ref_mem[27'h10]   = 32'hDEAD_BEEF;
        cache_mem[27'h10] = 32'hDEAD_BEEF;
        fixed_lat = 5;
        n = rsp_count;
        send_cmd(27'h10, 32'h0, 1'b0, 1'b0);
        wait_idle("read");
        check("read_rsp_count", 64'(rsp_count - n), 64'd1);

        // Write then read the same word
        fixed_lat = 2;
        n = rsp_count;
        send_cmd(27'h20, 32'h1234_5678, 1'b1, 1'b0);
        send_cmd(27'h20, 32'h0, 1'b0, 1'b0);
        wait_idle("wr_rd");
        check("wr_rd_rsp_count", 64'(rsp_count - n), 64'd2);

        // Fill the queue against a stalled cache
        cache_stall = 1'b1;
        fixed_lat = 1;
        n = rsp_count;
        send_cmd(27'h100, 32'h0, 1'b0, 1'b0);
        send_cmd(27'h101, 32'hA5A5_0101, 1'b1, 1'b0);
        send_cmd(27'h102, 32'h0, 1'b0, 1'b0);
        check("fill_cmd_ready", 64'(cmd_ready), 64'd0);
        check("fill_busy", 64'(busy), 64'd1);
        check("fill_state", 64'(state_dbg), 64'(ST_REQ));
        repeat (10) @(negedge sys_clk);
        check("fill_cmd_ready_hold", 64'(cmd_ready), 64'd0);
        cache_stall = 1'b0;
        wait_idle("fill");
        check("fill_rsp_count", 64'(rsp_count - n), 64'd3);

        // Random traffic over a small address window so reads hit earlier writes
        fixed_lat = -1;
        for (int i = 0; i < 60; i++) begin
            a = 27'($urandom_range(0, 15));
            send_cmd(a, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        end
        wait_idle("random");

`ifdef MEM_REQ_TIMEOUT_EN
        cache_stall = 1'b1;
        send_cmd(27'h55, 32'h0, 1'b0, 1'b1);
        g = 0;
        while (!cpu_req_valid && g < 50) begin
            @(negedge sys_clk);
            g++;
        end
        cnt = 0;
        while (cpu_req_valid && cnt < 200) begin
            cnt++;
            @(negedge sys_clk);
        end
        check("tmo_valid_cycles", 64'(cnt), 64'(TMO));
        wait_idle("tmo");
        cache_stall = 1'b0;
`else
        cache_stall = 1'b1;
        n = rsp_count;
        send_cmd(27'h55, 32'h0, 1'b0, 1'b0);
        repeat (1000) @(negedge sys_clk);
        check("notmo_req_valid", 64'(cpu_req_valid), 64'd1);
        check("notmo_state", 64'(state_dbg), 64'(ST_REQ));
        check("notmo_no_rsp", 64'(rsp_count - n), 64'd0);
        cache_stall = 1'b0;
        wait_idle("notmo");
`endif

        // Reset in the middle of a request with a second command queued
        cache_stall = 1'b1;
        send_cmd(27'h40, 32'h0, 1'b0, 1'b0);
        send_cmd(27'h41, 32'h0, 1'b0, 1'b0);
        @(negedge sys_clk);
        check("mid_req_valid", 64'(cpu_req_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_req_valid", 64'(cpu_req_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("mid_rst_state", 64'(state_dbg), 64'(ST_IDLE));
        exp_q.delete();
        exp_req_q.delete();
        n = rsp_count;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        cache_stall = 1'b0;
        @(posedge sys_clk);
        #1 force_ready = 1'b1;
        @(posedge sys_clk);
        #1 force_ready = 1'b0;
        repeat (10) @(negedge sys_clk);
        check("post_rst_no_rsp", 64'(rsp_count - n), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_req_valid", 64'(cpu_req_valid), 64'd0);

        // Spurious cache strobe while idle with an empty queue
        n = rsp_count;
        @(posedge sys_clk);
        #1 force_ready = 1'b1;
        @(posedge sys_clk);
        #1 force_ready = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("spur_no_rsp", 64'(rsp_count - n), 64'd0);
        check("spur_state", 64'(state_dbg), 64'(ST_IDLE));
        check("spur_busy", 64'(busy), 64'd0);

        // Traffic still flows normally afterwards
        send_cmd(27'h10, 32'h0, 1'b0, 1'b0);
        wait_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 Parameter: DEPTH, default 2, command queue entries (power of two, >=2).
REQ-002 Parameter: TIMEOUT_CYCLES, default 4096, REQ-state cycles before abort (used only with MEM_REQ_TIMEOUT_EN).
REQ-003 The block has one clock; reset is asynchronous and active-high. Ports: sys_clk  in  1  clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 cmd_valid  in  1  pipeline offers a command; cmd_ready  out  1  queue can accept.
REQ-006 cmd_addr  in  27  word address; cmd_wdata  in  32  store data; cmd_rw  in  1  1=write, 0=read.
REQ-007 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  32  load data; rsp_err  out  1  aborted by timeout.
REQ-008 busy  out  1  queue non-empty or request outstanding.
REQ-009 cpu_req_addr  out  27; cpu_req_data  out  32; cpu_req_rw  out  1; cpu_req_valid  out  1  request to cache.
REQ-010 cpu_res_data  in  32; cpu_res_ready  in  1  cache completion strobe.

Function
REQ-011 Command accepted on the sys_clk edge where cmd_valid && cmd_ready; cmd_ready SHALL equal !full && !rst.
REQ-012 Push and pop in the same cycle SHALL leave the count unchanged; pointers wrap modulo DEPTH.
REQ-013 FSM states IDLE, REQ, RESP; IDLE with queue non-empty SHALL pop the head into request registers and enter REQ the next cycle.
REQ-014 In REQ, cpu_req_valid=1 and cpu_req_addr/data/rw SHALL be held stable until the cycle cpu_res_ready=1.
REQ-015 On cpu_res_ready in REQ: capture cpu_res_data (reads) or 0 (writes), deassert cpu_req_valid next cycle, enter RESP.
REQ-016 RESP SHALL drive rsp_valid=1 for exactly one cycle with captured data, rsp_err=0, then return to IDLE.
REQ-017 cpu_req_valid SHALL be low for at least one cycle between consecutive requests; minimum request-to-request spacing is cache latency + 2 cycles.
REQ-018 cpu_res_ready outside REQ SHALL be ignored.
REQ-019 Responses SHALL be returned in command order; rsp has no backpressure.
REQ-020 cpu_req_data SHALL be 0 for reads; addresses pass unmodified.
REQ-021 busy = (state != IDLE) || queue non-empty.

Reset
REQ-022 Reset SHALL force: queue empty, state IDLE, all outputs 0 (cmd_ready 0 while rst high, 1 the first cycle after release).
REQ-023 Reset mid-request SHALL drop cpu_req_valid immediately, discard queued commands, and emit no response; a late cpu_res_ready is ignored.

Configuration
REQ-024 Macro MEM_REQ_TIMEOUT_EN defined: a counter clears on REQ entry; after TIMEOUT_CYCLES in REQ without cpu_res_ready, the block drops cpu_req_valid and enters RESP with rsp_err=1, rsp_rdata=0.
REQ-025 MEM_REQ_TIMEOUT_EN undefined: no counter, rsp_err tied 0, REQ waits indefinitely.

Structure
REQ-026 Package mem_req_pkg SHALL hold mem_cmd_t (addr 27, data 32, rw 1), the FSM state enum, and width constants ADDR_W=27, DATA_W=32.
REQ-027 Queue SHALL be sub-module mem_req_fifo (parameter DEPTH, mem_cmd_t payload, full/empty outputs).

Verification
REQ-028 Read: cmd addr=0x0000010, rw=0; cache ready 5 cycles later with 0xDEADBEEF -> single rsp_valid, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-029 Write then read: write 0x12345678 to 0x0000020, then read 0x0000020 -> cpu_req_data=0x12345678 on write, two in-order responses, valid low >=1 cycle between.
REQ-030 Fill: 3 back-to-back commands, cache stalled -> cmd_ready low after 2 queued + 1 outstanding; all 3 complete in order after release.
REQ-031 Timeout (macro on, TIMEOUT_CYCLES=16): no cpu_res_ready -> cpu_req_valid drops after 16 cycles, rsp_err=1, rsp_rdata=0; macro off -> still waiting at 1000 cycles.
REQ-032 Reset during REQ: rst pulse at cycle 3 of a read -> cpu_req_valid 0 immediately, no rsp_valid, busy=0, later cpu_res_ready ignored.
REQ-033 Spurious cpu_res_ready in IDLE with empty queue -> no rsp_valid, state unchanged.
